uart_tx_arbiter: RTL and testbench

// - Round-robin arbiter and sequencer that shares one UART transmitter (txlogic) among NUM_REQ byte sources.
// - Sits between the requesters and the transmitter's tx_en/tx_data_in inputs. Issues one launch per byte.
// - Holds off the next byte until the transmitter reports the frame is complete.
// - Flags a transmitter that never acknowledges a launch.

---
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter and launch sequencer that shares one UART transmitter
//   among NUM_REQ byte sources. One byte is launched per grant; the next
//   launch waits until the transmitter has raised and dropped tx_busy, or
//   until the launch has timed out (err pulse, byte dropped).
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   req          per-requester request, held together with its byte
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   gnt          one-hot 1-cycle pulse: that requester's byte was accepted
//   tx_busy      transmitter frame-in-flight indication
//   tx_en        1-cycle launch strobe to the transmitter
//   tx_data_in   launched byte, held until the next launch
//   tx_owner     index of the last granted requester
//   idle         high while the sequencer is in IDLE
//   err          1-cycle pulse when tx_busy never rose after a launch
//   o_dbg_state  current sequencer state (debug visibility)
//
// Handshake: a requester raises req with its byte on req_data and holds both
// until it sees gnt. gnt and tx_en are high in the same cycle; the byte was
// captured on the edge that started that cycle. On the cycle after gnt the
// requester either drops req or presents its next byte; a req still high
// when the arbiter is next in IDLE is taken as a new byte.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        tx_busy,
  output logic                        tx_en,
  output logic [DATA_W-1:0]           tx_data_in,
  output logic [$clog2(NUM_REQ)-1:0]  tx_owner,
  output logic                        idle,
  output logic                        err,
  output logic [1:0]                  o_dbg_state
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_ptr;
  logic [TMR_W-1:0]    r_timer;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_tx_en;
  logic [DATA_W-1:0]   r_tx_data;
  logic [SEL_W-1:0]    r_owner;
  logic                r_idle;
  logic                r_err;

  state_t              w_state_nxt;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic [TMR_W-1:0]    w_timer_nxt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic                w_tx_en_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [SEL_W-1:0]    w_owner_nxt;
  logic                w_idle_nxt;
  logic                w_err_nxt;

  logic                w_any;
  logic [SEL_W-1:0]    w_sel;
  logic [SEL_W:0]      w_sum;

  // Round-robin pick: first set req bit scanning ptr, ptr+1, ... wrapping.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (w_sum >= (SEL_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (SEL_W+1)'(NUM_REQ);
      end
      if (!w_any && req[w_sum[SEL_W-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_sum[SEL_W-1:0];
      end
    end
  end

  // Next state and next values of the registered outputs. The launch
  // outputs are loaded on the IDLE->LAUNCH edge so tx_en/gnt are high
  // exactly while the state register holds LAUNCH.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_timer_nxt = r_timer;
    w_gnt_nxt   = '0;
    w_tx_en_nxt = 1'b0;
    w_data_nxt  = r_tx_data;
    w_owner_nxt = r_owner;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A transmitter still finishing a frame blocks the launch.
        if (w_any && !tx_busy) begin
          w_state_nxt       = S_LAUNCH;
          w_tx_en_nxt       = 1'b1;
          w_gnt_nxt[w_sel]  = 1'b1;
          w_data_nxt        = req_data[int'(w_sel)*DATA_W +: DATA_W];
          w_owner_nxt       = w_sel;
          w_ptr_nxt         = (w_sel == SEL_W'(NUM_REQ-1)) ? '0 : w_sel + 1'b1;
        end
      end
      S_LAUNCH: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // err is raised as the timer steps onto its last value, so the
        // pulse sits in the final WAIT_BUSY cycle and never overlaps idle.
        if (r_timer == TMR_W'(BUSY_TIMEOUT-1)) begin
          w_state_nxt = S_IDLE;
        end else if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          if (r_timer == TMR_W'(BUSY_TIMEOUT-2)) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_idle_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_timer   <= '0;
      r_gnt     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_owner   <= '0;
      r_idle    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timer   <= w_timer_nxt;
      r_gnt     <= w_gnt_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_data <= w_data_nxt;
      r_owner   <= w_owner_nxt;
      r_idle    <= w_idle_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign tx_en       = r_tx_en;
  assign tx_data_in  = r_tx_data;
  assign tx_owner    = r_owner;
  assign idle        = r_idle;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Cycle-indexed bench. Each negedge k: compare DUT outputs of cycle k with
//   the model prediction, then drive inputs for cycle k and predict cycle
//   k+1. The model works with launch/idle/err cycle indices derived from the
//   transmitter timing it schedules itself (busy rises d cycles after a
//   launch and stays high F cycles), not with the DUT's state encoding.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int BT      = 16;
  localparam int SEL_W   = $clog2(NUM_REQ);
  localparam int QW      = SEL_W + DATA_W;

  // clock / reset block
  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NUM_REQ-1:0]         req = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_data = '0;
  logic                       tx_busy = 1'b0;
  logic [NUM_REQ-1:0]         gnt;
  logic                       tx_en;
  logic [DATA_W-1:0]          tx_data_in;
  logic [SEL_W-1:0]           tx_owner;
  logic                       idle;
  logic                       err;
  logic [1:0]                 dbg_state;

  always #10 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data_in(tx_data_in),
    .tx_owner(tx_owner), .idle(idle), .err(err), .o_dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [QW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // stimulus knobs (next-cycle inputs)
  logic                       s_rst = 1'b1;
  logic [NUM_REQ-1:0]         s_req = '0;
  logic [NUM_REQ*DATA_W-1:0]  s_data = '0;
  int dead_mode  = 0;   // 0 transmitter answers, 1 never answers, 2 sometimes
  int fix_d      = 0;   // 0 -> random 1..4
  int fix_f      = 0;   // 0 -> random 1..f_max
  int f_max      = 6;
  int force_busy = 0;   // cycles of stale busy (transmitter finishing)

  // model state
  int  cyc = 0;
  bit  m_valid = 0;
  int  m_ptr = 0;
  int  m_idle_from = 0;
  int  m_err_at = -1;
  int  m_cur_f = 0;
  int  t_rise = 0;
  int  t_fall = 0;
  int  obs_last = -1;
  int  obs_last_f = 0;
  logic last_busy = 1'b0;
  bit  exp_valid = 0;
  logic                exp_tx_en = 0;
  logic [NUM_REQ-1:0]  exp_gnt = '0;
  logic [DATA_W-1:0]   exp_data = '0;
  logic [SEL_W-1:0]    exp_owner = '0;
  logic                exp_idle = 1;
  logic                exp_err = 0;

  // driver task: one clock cycle
  task automatic tick();
    logic busy_now;
    int w, d, f, lc;
    bit dead;
    logic [QW-1:0] e;
    @(negedge clk);
    cyc++;
    if (exp_valid) begin
      check_eq("tx_en",    32'(tx_en),      32'(exp_tx_en));
      check_eq("gnt",      32'(gnt),        32'(exp_gnt));
      check_eq("tx_data",  32'(tx_data_in), 32'(exp_data));
      check_eq("tx_owner", 32'(tx_owner),   32'(exp_owner));
      check_eq("idle",     32'(idle),       32'(exp_idle));
      check_eq("err",      32'(err),        32'(exp_err));
      if (tx_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("launch", 32'({tx_owner, tx_data_in}), 32'(e));
        end else begin
          check_eq("launch_unexpected", 32'(1), 32'(0));
        end
        check_eq("en_while_busy", 32'(last_busy), 32'(0));
        if (obs_last >= 0 && obs_last_f > 0)
          check_eq("spacing", 32'(cyc - obs_last >= obs_last_f + 3), 32'(1));
        obs_last   = cyc;
        obs_last_f = m_cur_f;
      end
    end
    // drive cycle cyc
    busy_now = (force_busy > 0) || (cyc >= t_rise && cyc < t_fall);
    if (force_busy > 0) force_busy--;
    rst      = s_rst;
    req      = s_req;
    req_data = s_data;
    tx_busy  = busy_now;
    // predict cycle cyc+1
    if (s_rst) begin
      m_valid = 1; m_ptr = 0; m_idle_from = cyc + 1; m_err_at = -1;
      t_rise = 0; t_fall = 0; obs_last = -1; m_cur_f = 0;
      exp_q.delete();
      exp_tx_en = 0; exp_gnt = '0; exp_data = '0; exp_owner = '0;
      exp_idle = 1; exp_err = 0;
    end else if (m_valid) begin
      exp_tx_en = 0;
      exp_gnt   = '0;
      exp_err   = (cyc + 1 == m_err_at);
      if (cyc >= m_idle_from && s_req != '0 && !busy_now) begin
        w = -1;
        for (int off = 0; off < NUM_REQ; off++) begin
          int idx;
          idx = (m_ptr + off) % NUM_REQ;
          if (w < 0 && s_req[idx]) w = idx;
        end
        exp_tx_en    = 1;
        exp_gnt      = '0;
        exp_gnt[w]   = 1'b1;
        exp_data     = s_data[w*DATA_W +: DATA_W];
        exp_owner    = SEL_W'(w);
        m_ptr        = (w + 1) % NUM_REQ;
        exp_q.push_back({exp_owner, exp_data});
        lc   = cyc + 1;
        dead = (dead_mode == 1) || (dead_mode == 2 && $urandom_range(0, 7) == 0);
        if (dead) begin
          m_err_at    = lc + BT;
          m_idle_from = lc + BT + 1;
          m_cur_f     = 0;
        end else begin
          d = (fix_d > 0) ? fix_d : $urandom_range(1, 4);
          f = (fix_f > 0) ? fix_f : $urandom_range(1, f_max);
          t_rise      = lc + d;
          t_fall      = lc + d + f;
          m_idle_from = lc + d + f + 1;
          m_cur_f     = f;
        end
      end
      exp_idle = (cyc + 1 >= m_idle_from);
    end
    exp_valid = m_valid;
    last_busy = busy_now;
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit found;
    // single request, fixed frame timing
    do_reset();
    fix_d = 2; fix_f = 10;
    s_data = {8'h11, 8'h55, 8'h22, 8'h33};
    s_req = 4'b0100;
    run(3);
    s_req = 4'b0000;
    run(20);

    // all requesters held: 0,1,2,3,0,...
    fix_d = 0; fix_f = 0; f_max = 6;
    do_reset();
    s_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    s_req = 4'b1111;
    run(150);

    // requesters 0 and 3 only: 0,3,0,3
    do_reset();
    s_req = 4'b1001;
    run(80);

    // transmitter never answers: err 16 cycles after launch, ptr advanced
    do_reset();
    dead_mode = 1;
    s_data = {8'h03, 8'h02, 8'hF0, 8'h00};
    s_req = 4'b0010;
    run(2);
    s_req = 4'b0110;
    run(45);
    dead_mode = 0;

    // long frames, back-to-back requests
    do_reset();
    f_max = 20;
    s_req = 4'b1111;
    run(200);

    // reset in the middle of a frame with stale busy afterwards
    do_reset();
    fix_f = 8;
    s_req = 4'b1111;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (cyc + 1 >= t_rise + 2 && cyc + 1 < t_fall) found = 1;
    end
    check_eq("rst_window_found", 32'(found), 32'(1));
    force_busy = 4;
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    fix_f = 0;
    run(40);

    // randomized traffic with occasional dead launches and resets
    dead_mode = 2;
    f_max = 12;
    for (int n = 0; n < 2500; n++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if ($urandom_range(0, 5) == 0) begin
          s_req[r] = ~s_req[r];
          s_data[r*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      s_rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    s_rst = 1'b0;
    s_req = '0;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
